// File: rtl/ram_sdp_rdw.sv
// Simple-dual-port synchronous RAM: one write port, one read port, byte-lane enables,
// selectable read-during-write policy, optional output register and a post-reset init sweep.
module ram_sdp_rdw #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 2,
  parameter int                RDW_MODE = 0,
  parameter int                OUT_REG  = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      wa,
  input  logic [DATA_W-1:0]      d_i,
  input  logic [DATA_W/8-1:0]    be,
  input  logic                   re,
  input  logic [ADDR_W-1:0]      ra,
  output logic [DATA_W-1:0]      d_o,
  output logic                   d_o_valid,
  output logic                   busy
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   cnt, cnt_nx;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   q1;
  logic                v1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == ST_INIT) begin
      cnt_nx = cnt + 1'b1;
      if (cnt == ADDR_W'(DEPTH - 1)) state_nx = ST_READY;
    end
  end

  assign busy = (state == ST_INIT);

  // Array holds no reset; the sweep owns the write port until it finishes.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt] <= INIT_VAL;
    end else if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[wa][8*i +: 8] <= d_i[8*i +: 8];
      end
    end
  end

  // Write-first mode forwards the enabled lanes of the incoming word on a same-address hit.
  always_comb begin
    rd_word = mem[ra];
    if (RDW_MODE == 1 && we && (wa == ra)) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) rd_word[8*i +: 8] = d_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= re && !busy;
      if (re && !busy) q1 <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] q2;
      logic              v2;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q2 <= '0;
          v2 <= 1'b0;
        end else begin
          v2 <= v1;
          if (v1) q2 <= q1;
        end
      end
      assign d_o       = q2;
      assign d_o_valid = v2;
    end else begin : g_noreg
      assign d_o       = q1;
      assign d_o_valid = v1;
    end
  endgenerate

endmodule

// File: tb/tb_ram_sdp_rdw.sv
// Directed bench: three instances (read-first, write-first, read-first with output
// register) share one stimulus stream; each is checked against hand-computed values.
module tb_ram_sdp_rdw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we, re;
  logic [2:0]  wa, ra;
  logic [15:0] d_i;
  logic [1:0]  be;

  logic [15:0] d_o_a, d_o_b, d_o_c;
  logic        v_a, v_b, v_c;
  logic        busy_a, busy_b, busy_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ram_sdp_rdw #(.DATA_W(16), .ADDR_W(3), .RDW_MODE(0), .OUT_REG(0), .INIT_VAL(16'h5A5A)) u_a (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .d_i(d_i), .be(be),
    .re(re), .ra(ra), .d_o(d_o_a), .d_o_valid(v_a), .busy(busy_a));

  ram_sdp_rdw #(.DATA_W(16), .ADDR_W(3), .RDW_MODE(1), .OUT_REG(0), .INIT_VAL(16'h5A5A)) u_b (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .d_i(d_i), .be(be),
    .re(re), .ra(ra), .d_o(d_o_b), .d_o_valid(v_b), .busy(busy_b));

  ram_sdp_rdw #(.DATA_W(16), .ADDR_W(3), .RDW_MODE(0), .OUT_REG(1), .INIT_VAL(16'h5A5A)) u_c (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .d_i(d_i), .be(be),
    .re(re), .ra(ra), .d_o(d_o_c), .d_o_valid(v_c), .busy(busy_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; wa = '0; ra = '0; d_i = '0; be = '0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] b);
    we = 1'b1; wa = a; d_i = d; be = b; re = 1'b0;
    tick();
    we = 1'b0;
  endtask

  // Counts the sweep edges while checking busy before each and clear afterwards.
  task automatic sweep(input string tag);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_busy_a"}, busy_a, 1'b1);
      chk({tag, "_busy_c"}, busy_c, 1'b1);
      chk({tag, "_valid_a"}, v_a, 1'b0);
      tick();
    end
    chk({tag, "_done_a"}, busy_a, 1'b0);
    chk({tag, "_done_b"}, busy_b, 1'b0);
    chk({tag, "_done_c"}, busy_c, 1'b0);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    chk("rst_busy", busy_a, 1'b1);
    chk("rst_do_a", d_o_a, 16'h0000);
    chk("rst_do_c", d_o_c, 16'h0000);
    chk("rst_valid", v_a | v_b | v_c, 1'b0);

    // Requests held during the sweep must be ignored.
    @(posedge clk); #1;
    we = 1'b1; wa = 3'd0; d_i = 16'hFFFF; be = 2'b11; re = 1'b1; ra = 3'd0;
    rst_n = 1'b1;
    sweep("init");
    idle();

    // Back-to-back reads of the whole array.
    for (int k = 0; k < 8; k++) begin
      re = 1'b1; ra = 3'(k);
      tick();
      chk("init_rd_a", d_o_a, 16'h5A5A);
      chk("init_rd_va", v_a, 1'b1);
      chk("init_rd_b", d_o_b, 16'h5A5A);
      chk("init_rd_vc", v_c, (k == 0) ? 1'b0 : 1'b1);
      if (k > 0) chk("init_rd_c", d_o_c, 16'h5A5A);
    end
    re = 1'b0;
    tick();
    chk("rd_end_va", v_a, 1'b0);
    chk("rd_hold_a", d_o_a, 16'h5A5A);
    chk("rd_end_vc", v_c, 1'b1);
    tick();
    chk("rd_end_vc2", v_c, 1'b0);

    // Byte-lane writes.
    wr(3'd3, 16'h1234, 2'b01);
    re = 1'b1; ra = 3'd3;
    tick();
    re = 1'b0;
    chk("be01_a", d_o_a, 16'h5A34);
    chk("be01_b", d_o_b, 16'h5A34);
    wr(3'd3, 16'hFFFF, 2'b00);
    re = 1'b1; ra = 3'd3;
    tick();
    re = 1'b0;
    chk("be00_a", d_o_a, 16'h5A34);
    chk("be00_b", d_o_b, 16'h5A34);

    // Full-word collision.
    wr(3'd5, 16'h1111, 2'b11);
    we = 1'b1; wa = 3'd5; d_i = 16'h2222; be = 2'b11; re = 1'b1; ra = 3'd5;
    tick();
    we = 1'b0;
    chk("col11_old_a", d_o_a, 16'h1111);
    chk("col11_new_b", d_o_b, 16'h2222);
    tick();
    re = 1'b0;
    chk("col11_next_a", d_o_a, 16'h2222);
    chk("col11_next_b", d_o_b, 16'h2222);
    chk("col11_old_c", d_o_c, 16'h1111);

    // Partial-lane collision.
    wr(3'd5, 16'h1111, 2'b11);
    we = 1'b1; wa = 3'd5; d_i = 16'h2222; be = 2'b10; re = 1'b1; ra = 3'd5;
    tick();
    we = 1'b0;
    chk("col10_old_a", d_o_a, 16'h1111);
    chk("col10_mrg_b", d_o_b, 16'h2211);
    tick();
    re = 1'b0;
    chk("col10_next_a", d_o_a, 16'h2211);

    // Different addresses on the same edge are independent.
    we = 1'b1; wa = 3'd6; d_i = 16'hBEEF; be = 2'b11; re = 1'b1; ra = 3'd5;
    tick();
    we = 1'b0; ra = 3'd6;
    chk("indep_rd_b", d_o_b, 16'h2211);
    tick();
    re = 1'b0;
    chk("indep_wr_a", d_o_a, 16'hBEEF);

    // Output-register pipeline ordering.
    wr(3'd0, 16'hA000, 2'b11);
    wr(3'd1, 16'hA001, 2'b11);
    wr(3'd2, 16'hA002, 2'b11);
    re = 1'b1; ra = 3'd0;
    tick();
    chk("oreg_n_vc", v_c, 1'b0);
    ra = 3'd1;
    tick();
    chk("oreg_0_vc", v_c, 1'b1);
    chk("oreg_0_c", d_o_c, 16'hA000);
    ra = 3'd2;
    tick();
    re = 1'b0;
    chk("oreg_1_c", d_o_c, 16'hA001);
    tick();
    chk("oreg_2_c", d_o_c, 16'hA002);
    chk("oreg_2_vc", v_c, 1'b1);
    tick();
    chk("oreg_end_vc", v_c, 1'b0);
    chk("oreg_hold_c", d_o_c, 16'hA002);

    // Reset in the middle of a read stream.
    wr(3'd3, 16'h1234, 2'b11);
    re = 1'b1; ra = 3'd3;
    tick();
    ra = 3'd0;
    tick();
    chk("mid_pre_c", d_o_c, 16'h1234);
    chk("mid_pre_vc", v_c, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_do_c", d_o_c, 16'h0000);
    chk("mid_rst_vc", v_c, 1'b0);
    chk("mid_rst_do_a", d_o_a, 16'h0000);
    chk("mid_rst_va", v_a, 1'b0);
    chk("mid_rst_busy", busy_a, 1'b1);
    idle();
    tick();
    rst_n = 1'b1;
    sweep("reinit");
    re = 1'b1; ra = 3'd3;
    tick();
    re = 1'b0;
    chk("reinit_rd_a", d_o_a, 16'h5A5A);
    tick();
    chk("reinit_rd_c", d_o_c, 16'h5A5A);
    chk("reinit_rd_vc", v_c, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
